// File: rtl/fsm_cnt_ctrl.sv
// Run controller for a 2-bit enable-driven wrap counter: strobes en_o through a
// programmable prescaler, counts completed wraps and pulses done at the end of a run.
module fsm_cnt_ctrl #(
    parameter int unsigned PRESC_W = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PRESC_W-1:0] period,
    input  logic [CNT_W-1:0]   n_wraps,
    input  logic               wrap_i,
    output logic               en_o,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   wraps_left
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] per_q, per_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               en_q, busy_q, done_q;
    logic               wrap_ev_c;

    // en_q mirrors (RUN && presc==0), so a wrap is the counter leaving state 3 this edge
    assign wrap_ev_c = (state_q == ST_RUN) && en_q && wrap_i;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        per_d   = per_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (n_wraps != '0) begin
                        state_d = ST_RUN;
                        per_d   = period;
                        presc_d = period;
                        rem_d   = n_wraps;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                presc_d = (presc_q == '0) ? per_q : presc_q - PRESC_W'(1);
                if (wrap_ev_c && (rem_q != '0)) begin
                    rem_d = rem_q - CNT_W'(1);
                end
                // abort overrides completion; the wrap itself still counts
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wrap_ev_c && (rem_q == CNT_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            per_q   <= '0;
            rem_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            per_q   <= per_d;
            rem_q   <= rem_d;
            en_q    <= (state_d == ST_RUN) && (presc_d == '0);
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign en_o       = en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign wraps_left = rem_q;

endmodule

// File: tb/tb_fsm_cnt_ctrl.sv
// Bench for fsm_cnt_ctrl: directed scenarios then random commands, checked against
// a cycle-count reference model together with a 2-bit wrap counter driven by en_o.
module tb_fsm_cnt_ctrl;

    localparam int unsigned PRESC_W = 8;
    localparam int unsigned CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [PRESC_W-1:0] period = '0;
    logic [CNT_W-1:0]   n_wraps = '0;
    logic               wrap_i;
    logic               en_o, busy, done;
    logic [CNT_W-1:0]   wraps_left;

    logic [1:0] cnt = 2'd0;

    int checks = 0;
    int errors = 0;

    // Reference model: run position measured in cycles since the run began
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_t    = 0;
    int m_per  = 0;
    int m_rem  = 0;
    int m_cnt  = 0;

    fsm_cnt_ctrl #(.PRESC_W(PRESC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .period     (period),
        .n_wraps    (n_wraps),
        .wrap_i     (wrap_i),
        .en_o       (en_o),
        .busy       (busy),
        .done       (done),
        .wraps_left (wraps_left)
    );

    always #5 clk = ~clk;

    // The shared counter, never reset by the controller
    always @(posedge clk) if (en_o) cnt <= cnt + 2'd1;
    assign wrap_i = (cnt == 2'd3);

    function automatic bit exp_en();
        return m_run && ((m_t % (m_per + 1)) == m_per);
    endfunction

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic check_all();
        chk("en_o", int'(en_o), int'(exp_en()));
        chk("busy", int'(busy), int'(m_run));
        chk("done", int'(done), int'(m_done));
        chk("wraps_left", int'(wraps_left), m_rem);
        chk("counter", int'(cnt), m_cnt);
    endtask

    task automatic model_next(input bit s, input bit a, input int p, input int n);
        bit e, w;
        if (m_run) begin
            e = exp_en();
            w = e && (m_cnt == 3);
            if (e) m_cnt = (m_cnt + 1) % 4;
            if (w && m_rem > 0) m_rem = m_rem - 1;
            m_t = m_t + 1;
            if (a) m_run = 1'b0;
            else if (w && m_rem == 0) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (s && !a) begin
            if (n != 0) begin
                m_run = 1'b1;
                m_t   = 0;
                m_per = p;
                m_rem = n;
            end else begin
                m_done = 1'b1;
            end
        end
    endtask

    // Check outputs at the falling edge, then drive inputs for the next rising edge
    task automatic step(input bit s, input bit a, input int p, input int n);
        @(negedge clk);
        check_all();
        start   = s;
        abort   = a;
        period  = PRESC_W'(p);
        n_wraps = CNT_W'(n);
        model_next(s, a, p, n);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        int s_cnt;
        // Reset values
        #3;
        chk("rst_en_o", int'(en_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wraps_left", int'(wraps_left), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // 1: period 0, one wrap
        step(1, 0, 0, 1);
        idle_cycles(7);

        // 2: period 2, three wraps
        step(1, 0, 2, 3);
        idle_cycles(40);
        chk("counter_home", int'(cnt), 0);

        // 3: zero wraps gives an immediate done
        step(1, 0, 5, 0);
        idle_cycles(3);

        // 4: abort after two wraps, then a normal run
        step(1, 0, 1, 5);
        idle_cycles(15);
        step(0, 1, 0, 0);
        idle_cycles(3);
        chk("abort_left", int'(wraps_left), 3);
        step(1, 0, 0, 1);
        idle_cycles(7);

        // 5: start during RUN ignored; start with abort in IDLE ignored
        step(1, 0, 1, 2);
        idle_cycles(3);
        step(1, 0, 3, 7);
        idle_cycles(20);
        step(1, 1, 0, 2);
        idle_cycles(3);

        // Maximum period: en_o every 256 cycles
        step(1, 0, 255, 1);
        idle_cycles(4 * 256 + 4);

        // 6: asynchronous reset mid-run
        step(1, 0, 1, 4);
        idle_cycles(6);
        @(negedge clk);
        check_all();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en_o", int'(en_o), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_wraps_left", int'(wraps_left), 0);
        m_run = 1'b0; m_done = 1'b0; m_rem = 0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(4);

        // Random commands
        for (int i = 0; i < 3000; i++) begin
            s_cnt = ($urandom_range(0, 7) == 0) ? 1 : 0;
            step(s_cnt[0], ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
